apb_wb_bridge_v2: RTL and testbench

Parametrised APB4-slave to Wishbone-classic-master bridge, the successor of the fixed 10-bit-address bridge that fronts Wishbone peripherals such as the Ethernet MAC.
- Generalises data and address width.
- Adds APB4 byte strobes (PSTRB to SEL_O).
- Adds bounded Wishbone retry handling (RTY_I) with back-off.
- Adds a bus-timeout watchdog so a hung slave cannot stall the APB bus.
- Sits between the APB fabric and any Wishbone-slave IP; one bridge per peripheral.

---
 rtl/apb_wb_bridge_v2_pkg.sv | 20 ++
 rtl/apb_wb_watchdog.sv | 60 ++++++
 rtl/apb_wb_bridge_v2.sv | 170 +++++++++++++++++
 tb/tb_apb_wb_bridge_v2.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_wb_bridge_v2_pkg.sv
// Shared types and defaults for the APB4 to Wishbone-classic bridge.
package apb_wb_bridge_v2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam int DEF_TIMEOUT   = 256;
    localparam int DEF_MAX_RETRY = 3;
    localparam int DEF_BACKOFF   = 2;

    // Width of a counter that must hold 0..n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/apb_wb_watchdog.sv
// Request watchdog, retry counter and back-off timer for the bridge FSM.
module apb_wb_watchdog
    import apb_wb_bridge_v2_pkg::*;
#(
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int MAX_RETRY = DEF_MAX_RETRY,
    parameter int BACKOFF   = DEF_BACKOFF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_active,
    input  logic wait_active,
    input  logic retry_inc,
    input  logic retry_clr,
    output logic tmo_hit,
    output logic retry_max,
    output logic backoff_done
);

    localparam int TW = cnt_w(TIMEOUT);
    localparam int RW = cnt_w(MAX_RETRY);
    localparam int BW = cnt_w(BACKOFF);

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RTY_LAST = RW'(MAX_RETRY);
    localparam logic [BW-1:0] BO_LAST  = BW'(BACKOFF - 1);

    logic [TW-1:0] tmo_cnt;
    logic [RW-1:0] retry_cnt;
    logic [BW-1:0] bo_cnt;

    assign tmo_hit      = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
    assign retry_max    = (retry_cnt == RTY_LAST);
    assign backoff_done = (bo_cnt == BO_LAST);

    // Counters clear whenever their phase is inactive and saturate at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            retry_cnt <= '0;
            bo_cnt    <= '0;
        end else begin
            if (!req_active)
                tmo_cnt <= '0;
            else if (tmo_cnt != TMO_LAST)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (retry_clr)
                retry_cnt <= '0;
            else if (retry_inc && !retry_max)
                retry_cnt <= retry_cnt + 1'b1;

            if (!wait_active)
                bo_cnt <= '0;
            else if (!backoff_done)
                bo_cnt <= bo_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/apb_wb_bridge_v2.sv
// APB4 slave to Wishbone-classic master bridge with retry back-off
// and a request watchdog.
module apb_wb_bridge_v2
    import apb_wb_bridge_v2_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int MAX_RETRY  = DEF_MAX_RETRY,
    parameter int BACKOFF    = DEF_BACKOFF
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [ADDR_WIDTH+1:2]   PADDR,
    input  logic                    PWRITE,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic                    PREADY,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PSLVERR,
    input  logic                    ACK_I,
    input  logic                    ERR_I,
    input  logic                    RTY_I,
    input  logic [DATA_WIDTH-1:0]   DAT_I,
    output logic                    CYC_O,
    output logic                    STB_O,
    output logic                    WE_O,
    output logic [ADDR_WIDTH-1:0]   ADR_O,
    output logic [DATA_WIDTH/8-1:0] SEL_O,
    output logic [DATA_WIDTH-1:0]   DAT_O,
    output logic                    timeout_o,
    output logic                    retry_exh_o
);

    state_t state;
    logic   dropped;
    logic   tmo_hit;
    logic   retry_max;
    logic   backoff_done;
    logic   fin;
    logic   fin_err;
    logic   go_wait;
    logic   exh;
    logic   tmo_abort;
    logic   discard;

    apb_wb_watchdog #(
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY),
        .BACKOFF   (BACKOFF)
    ) u_wdog (
        .clk          (PCLK),
        .rst_n        (PRESETn),
        .req_active   (state == ST_REQ),
        .wait_active  (state == ST_WAIT),
        .retry_inc    (go_wait),
        .retry_clr    (state == ST_IDLE || state == ST_DONE),
        .tmo_hit      (tmo_hit),
        .retry_max    (retry_max),
        .backoff_done (backoff_done)
    );

    // Slave response resolution: ACK > ERR > RTY > watchdog.
    always_comb begin
        fin       = 1'b0;
        fin_err   = 1'b0;
        go_wait   = 1'b0;
        exh       = 1'b0;
        tmo_abort = 1'b0;
        if (state == ST_REQ) begin
            if (ACK_I) begin
                fin = 1'b1;
            end else if (ERR_I) begin
                fin     = 1'b1;
                fin_err = 1'b1;
            end else if (RTY_I && !retry_max) begin
                go_wait = 1'b1;
            end else if (RTY_I) begin
                fin     = 1'b1;
                fin_err = 1'b1;
                exh     = 1'b1;
            end else if (tmo_hit) begin
                fin       = 1'b1;
                fin_err   = 1'b1;
                tmo_abort = 1'b1;
            end
        end
    end

    assign discard = dropped || !PSEL;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= ST_IDLE;
            dropped     <= 1'b0;
            CYC_O       <= 1'b0;
            STB_O       <= 1'b0;
            WE_O        <= 1'b0;
            PREADY      <= 1'b0;
            PSLVERR     <= 1'b0;
            PRDATA      <= '0;
            ADR_O       <= '0;
            SEL_O       <= '0;
            DAT_O       <= '0;
            timeout_o   <= 1'b0;
            retry_exh_o <= 1'b0;
        end else begin
            timeout_o   <= tmo_abort;
            retry_exh_o <= exh;
            unique case (state)
                ST_IDLE: begin
                    dropped <= 1'b0;
                    if (PSEL && !PENABLE) begin
                        ADR_O <= PADDR;
                        WE_O  <= PWRITE;
                        DAT_O <= PWDATA;
                        SEL_O <= PWRITE ? PSTRB : '1;
                        if (PWRITE && PSTRB == '0) begin
                            state  <= ST_DONE;
                            PREADY <= 1'b1;
                        end else begin
                            state <= ST_REQ;
                            CYC_O <= 1'b1;
                            STB_O <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (!PSEL)
                        dropped <= 1'b1;
                    if (go_wait) begin
                        state <= ST_WAIT;
                        CYC_O <= 1'b0;
                        STB_O <= 1'b0;
                    end else if (fin) begin
                        CYC_O <= 1'b0;
                        STB_O <= 1'b0;
                        // An abandoned APB access gets no response.
                        if (discard) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_DONE;
                            PREADY  <= 1'b1;
                            PSLVERR <= fin_err;
                            if (ACK_I && !WE_O)
                                PRDATA <= DAT_I;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!PSEL)
                        dropped <= 1'b1;
                    if (backoff_done) begin
                        state <= ST_REQ;
                        CYC_O <= 1'b1;
                        STB_O <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_wb_bridge_v2.sv
// Bench for apb_wb_bridge_v2: directed and random APB transfers against
// an episode-level model of the Wishbone slave outcome.
module tb_apb_wb_bridge_v2;

    localparam int TMO  = 16;
    localparam int MAXR = 3;
    localparam int BO   = 2;

    localparam int K_ACK = 0;
    localparam int K_ERR = 1;
    localparam int K_RTY = 2;
    localparam int K_AE  = 3;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic [11:2] PADDR = '0;
    logic        PWRITE = 1'b0;
    logic [31:0] PWDATA = '0;
    logic [3:0]  PSTRB = '0;
    logic        ACK_I = 1'b0;
    logic        ERR_I = 1'b0;
    logic        RTY_I = 1'b0;
    logic [31:0] DAT_I = '0;

    logic        PREADY, PSLVERR, CYC_O, STB_O, WE_O;
    logic        timeout_o, retry_exh_o;
    logic [31:0] PRDATA, DAT_O;
    logic [9:0]  ADR_O;
    logic [3:0]  SEL_O;

    logic        PREADY_z, PSLVERR_z, CYC_Oz, STB_Oz, WE_Oz;
    logic        timeout_oz, retry_exh_oz;
    logic [31:0] PRDATA_z, DAT_Oz;
    logic [9:0]  ADR_Oz;
    logic [3:0]  SEL_Oz;

    apb_wb_bridge_v2 #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10),
        .TIMEOUT(TMO), .MAX_RETRY(MAXR), .BACKOFF(BO)
    ) u_dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
        .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I), .DAT_I(DAT_I),
        .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O),
        .SEL_O(SEL_O), .DAT_O(DAT_O),
        .timeout_o(timeout_o), .retry_exh_o(retry_exh_o)
    );

    apb_wb_bridge_v2 #(
        .DATA_WIDTH(32), .ADDR_WIDTH(10),
        .TIMEOUT(0), .MAX_RETRY(MAXR), .BACKOFF(BO)
    ) u_dut_z (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PREADY(PREADY_z), .PRDATA(PRDATA_z), .PSLVERR(PSLVERR_z),
        .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I), .DAT_I(DAT_I),
        .CYC_O(CYC_Oz), .STB_O(STB_Oz), .WE_O(WE_Oz), .ADR_O(ADR_Oz),
        .SEL_O(SEL_Oz), .DAT_O(DAT_Oz),
        .timeout_o(timeout_oz), .retry_exh_o(retry_exh_oz)
    );

    always #5 PCLK = ~PCLK;

    int total = 0;
    int bad = 0;
    int sd[$];
    int sk[$];
    logic [31:0] prd_exp = '0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Runs one APB transfer; the slave answers each strobe episode from
    // the (delay, kind) script in sd/sk, silent once the script runs out.
    task automatic xfer(input logic wr, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] rdv, input string tag);
        int e_lat, e_cyc, e_tmo, e_exh, rtys, i, dl, kd;
        int lat, cyc, cyc_hi, tmo_n, exh_n, badfld, wcnt, qi;
        logic e_err, e_ack, done, got_err, cyc_done;
        logic [31:0] got_rd;
        logic [3:0] esel;

        e_lat = 1; e_cyc = 0; e_tmo = 0; e_exh = 0;
        e_err = 1'b0; e_ack = 1'b0;
        if (!(wr && s == 4'h0)) begin
            rtys = 0; done = 1'b0; i = 0;
            while (!done) begin
                dl = (i < sd.size()) ? sd[i] : TMO;
                kd = (i < sk.size()) ? sk[i] : K_ACK;
                if (dl >= TMO) begin
                    e_lat += TMO; e_cyc += TMO;
                    e_err = 1'b1; e_tmo = 1; done = 1'b1;
                end else begin
                    e_lat += dl + 1; e_cyc += dl + 1;
                    if (kd == K_RTY) begin
                        if (rtys < MAXR) begin
                            rtys++; e_lat += BO;
                        end else begin
                            e_err = 1'b1; e_exh = 1; done = 1'b1;
                        end
                    end else begin
                        e_err = (kd == K_ERR);
                        e_ack = (kd != K_ERR);
                        done = 1'b1;
                    end
                end
                i++;
            end
        end

        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
        PADDR = a; PWDATA = d; PSTRB = s; DAT_I = rdv;
        esel = wr ? s : 4'hF;
        cyc = 0; lat = -1; cyc_hi = 0; tmo_n = 0; exh_n = 0;
        badfld = 0; wcnt = 0; qi = 0;
        got_err = 1'b0; got_rd = '0; cyc_done = 1'b0;
        while (lat < 0 && cyc < 300) begin
            @(negedge PCLK);
            cyc++;
            PENABLE = 1'b1;
            if (timeout_o) tmo_n++;
            if (retry_exh_o) exh_n++;
            ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0;
            if (PREADY) begin
                lat = cyc; got_err = PSLVERR;
                got_rd = PRDATA; cyc_done = CYC_O;
            end else if (CYC_O && STB_O) begin
                cyc_hi++;
                if (ADR_O !== a || WE_O !== wr || SEL_O !== esel ||
                    (wr && DAT_O !== d))
                    badfld++;
                if (qi < sd.size() && wcnt == sd[qi]) begin
                    ACK_I = (sk[qi] == K_ACK || sk[qi] == K_AE);
                    ERR_I = (sk[qi] == K_ERR || sk[qi] == K_AE);
                    RTY_I = (sk[qi] == K_RTY);
                    qi++; wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        chk({tag, "_ready_once"}, PREADY, 0);
        chk({tag, "_latency"}, lat, e_lat);
        chk({tag, "_slverr"}, got_err, e_err);
        chk({tag, "_cyc_cycles"}, cyc_hi, e_cyc);
        chk({tag, "_timeout_pulses"}, tmo_n, e_tmo);
        chk({tag, "_exh_pulses"}, exh_n, e_exh);
        chk({tag, "_wb_fields"}, badfld, 0);
        chk({tag, "_cyc_in_done"}, cyc_done, 0);
        if (!wr && e_ack) prd_exp = rdv;
        chk({tag, "_prdata"}, got_rd, prd_exp);
        sd.delete();
        sk.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_time_limit obs=expired exp=finished");
        $fatal(1);
    end

    initial begin
        int nr, kd, zlow, zt, zr, pr;

        @(negedge PCLK);
        @(negedge PCLK);
        chk("rst_ctrl", {CYC_O, STB_O, WE_O, PREADY, PSLVERR,
                         timeout_o, retry_exh_o}, 0);
        chk("rst_prdata", PRDATA, 0);
        chk("rst_adr_sel", {ADR_O, SEL_O}, 0);
        chk("rst_dat_o", DAT_O, 0);
        chk("rst_z_ctrl", {CYC_Oz, STB_Oz, WE_Oz, PREADY_z, PSLVERR_z,
                           timeout_oz, retry_exh_oz, ADR_Oz, SEL_Oz}, 0);
        chk("rst_z_data", {PRDATA_z, DAT_Oz}, 0);
        PRESETn = 1'b1;

        sd = '{0}; sk = '{K_ACK};
        xfer(1'b0, 10'h010, 32'h0, 4'h0, 32'hDEADBEEF, "rd_zw");

        sd = '{0}; sk = '{K_ACK};
        xfer(1'b1, 10'h3FF, 32'h12345678, 4'b0101, 32'h0, "wr_strb");

        xfer(1'b1, 10'h004, 32'hA5A5A5A5, 4'h0, 32'h0, "wr_nostrb");

        sd = '{1, 0, 2}; sk = '{K_RTY, K_RTY, K_ACK};
        xfer(1'b0, 10'h020, 32'h0, 4'h0, 32'h0BADF00D, "rty2_ack");

        sd = '{0, 0, 1, 0}; sk = '{K_RTY, K_RTY, K_RTY, K_RTY};
        xfer(1'b0, 10'h021, 32'h0, 4'h0, 32'h11111111, "rty4");

        sd = '{0}; sk = '{K_AE};
        xfer(1'b0, 10'h030, 32'h0, 4'h0, 32'h5A5A1234, "ack_err");

        sd = '{3}; sk = '{K_ERR};
        xfer(1'b0, 10'h031, 32'h0, 4'h0, 32'h77777777, "err");

        for (int n = 0; n < 40; n++) begin
            nr = $urandom_range(0, 4);
            for (int j = 0; j < nr; j++) begin
                sd.push_back($urandom_range(0, 3));
                sk.push_back(K_RTY);
            end
            kd = $urandom_range(0, 2);
            if (kd == 2) kd = K_AE;
            sd.push_back($urandom_range(0, 5));
            sk.push_back(kd);
            xfer(1'($urandom_range(0, 1)), 10'($urandom), $urandom,
                 4'($urandom_range(0, 15)), $urandom, "rnd");
        end

        // APB master abandons a read while the WB cycle is in flight.
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 10'h005; DAT_I = 32'hFEEDFACE;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
        chk("drop_cyc_high", CYC_O, 1);
        @(negedge PCLK);
        ACK_I = 1'b1;
        @(negedge PCLK);
        ACK_I = 1'b0;
        chk("drop_cyc_low", CYC_O, 0);
        pr = 0;
        for (int c = 0; c < 6; c++) begin
            if (PREADY) pr++;
            @(negedge PCLK);
        end
        chk("drop_no_ready", pr, 0);
        chk("drop_prdata", PRDATA, prd_exp);

        // Silent slave: the 16-cycle watchdog fires, the disabled one never does.
        xfer(1'b0, 10'h02A, 32'h0, 4'h0, 32'hCAFEF00D, "tmo");
        zlow = 0; zt = 0; zr = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge PCLK);
            if (!CYC_Oz) zlow++;
            if (timeout_oz) zt++;
            if (PREADY_z) zr++;
        end
        chk("notmo_cyc_low", zlow, 0);
        chk("notmo_timeout", zt, 0);
        chk("notmo_ready", zr, 0);

        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = 10'h007; PWDATA = 32'h01020304; PSTRB = 4'hF;
        @(negedge PCLK);
        PENABLE = 1'b1;
        chk("rstreq_cyc_high", CYC_O, 1);
        @(negedge PCLK);
        #3 PRESETn = 1'b0;
        #1;
        chk("rstreq_ctrl", {CYC_O, STB_O, PREADY}, 0);
        chk("rstreq_z_ctrl", {CYC_Oz, STB_Oz, PREADY_z}, 0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        prd_exp = '0;
        chk("rstreq_prdata", PRDATA, 0);

        sd = '{0}; sk = '{K_ACK};
        xfer(1'b0, 10'h001, 32'h0, 4'h0, 32'hDEADBEEF, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
